// File: rtl/uart_fifo_rd_ctrl.sv
// uart_fifo_rd_ctrl: read sequencer between the TX FIFO read port and
// the UART transmit shifter. Issues paced FIFO reads, tracks them through
// the fixed FIFO read latency, and buffers returned bytes in a skid buffer
// presented as a valid/ready stream. A flush drains the FIFO and drops
// everything it reads.
//
// Ports:
//   CLK, RESET        clock, async active-high reset
//   enable            level, allows new FIFO reads
//   flush             single-cycle request to drain and discard
//   fifo_empty        FIFO EMPTY flag
//   fifo_do[7:0]      FIFO registered read data
//   fifo_rdb          FIFO read enable, active low
//   tx_data[7:0]      head byte of the skid buffer
//   tx_valid          tx_data holds a byte
//   tx_ready          consumer accepts on tx_valid & tx_ready
//   busy              not IDLE, bytes buffered, or reads in flight
//   flush_done        one-cycle pulse when a flush completes
//
// Optional macro UART_FIFO_RD_CTRL_STATS_EN adds saturating counters:
//   tx_count[15:0]    bytes accepted by the consumer
//   drop_count[15:0]  bytes discarded by flushes

module uart_fifo_rd_ctrl #(
  parameter int RD_LAT     = 2,
  parameter int SKID_DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       enable,
  input  logic       flush,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_do,
  output logic       fifo_rdb,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       flush_done
`ifdef UART_FIFO_RD_CTRL_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic [15:0] drop_count
`endif
);

  localparam int PW = (SKID_DEPTH > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [RD_LAT-1:0] r_inflight;
  logic [7:0]       r_mem [SKID_DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [2:0]       r_count;
  logic             r_flush_done;

  logic [1:0]       w_infl_cnt;
  logic             w_credit;
  logic             w_issue;
  logic             w_ret;
  logic             w_cap;
  logic             w_pop;
  logic             w_flush_go;
  logic             w_flush_exit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++)
      w_infl_cnt = w_infl_cnt + {1'b0, r_inflight[i]};
  end

  // Reads still in flight hold a reserved skid slot.
  assign w_credit = ({1'b0, r_count} + {2'b0, w_infl_cnt})
                    < 4'(SKID_DEPTH);

  // r_inflight[0] set means a read went out last cycle; skipping this
  // cycle lets fifo_empty settle after that read.
  assign w_issue = !fifo_empty && !r_inflight[0] &&
                   ((r_state == S_RUN && w_credit) ||
                    r_state == S_FLUSH);

  assign fifo_rdb   = !w_issue;
  assign w_ret      = r_inflight[RD_LAT-1];
  assign w_flush_go = flush && (r_state != S_FLUSH);
  assign w_cap      = w_ret && (r_state != S_FLUSH) && !w_flush_go;
  assign tx_valid   = (r_count != 3'd0);
  assign tx_data    = r_mem[r_head];
  assign w_pop      = tx_valid && tx_ready;
  assign busy       = (r_state != S_IDLE) || tx_valid || (|r_inflight);
  assign flush_done = r_flush_done;

  always_comb begin
    w_next       = r_state;
    w_flush_exit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (flush)       w_next = S_FLUSH;
        else if (enable) w_next = S_RUN;
      end
      S_RUN: begin
        if (flush)        w_next = S_FLUSH;
        else if (!enable) w_next = S_IDLE;
      end
      S_FLUSH: begin
        if (fifo_empty && r_inflight == '0) begin
          w_next       = S_IDLE;
          w_flush_exit = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_flush_done <= w_flush_exit;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_inflight <= '0;
    end else begin
      r_inflight[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++)
        r_inflight[i] <= r_inflight[i-1];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < SKID_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_flush_go) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_cap) begin
        r_mem[r_tail] <= fifo_do;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop)
        r_head <= ptr_inc(r_head);
      r_count <= r_count + {2'b0, w_cap} - {2'b0, w_pop};
    end
  end

`ifdef UART_FIFO_RD_CTRL_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_drop_count;
  logic [2:0]  w_drop_inc;
  logic [16:0] w_drop_sum;

  // On flush entry the buffered bytes not popped this cycle plus any
  // byte returning this cycle are lost; in FLUSH every return is lost.
  always_comb begin
    w_drop_inc = '0;
    if (w_flush_go)
      w_drop_inc = r_count - {2'b0, w_pop} + {2'b0, w_ret};
    else if (r_state == S_FLUSH)
      w_drop_inc = {2'b0, w_ret};
  end

  assign w_drop_sum = {1'b0, r_drop_count} + {14'b0, w_drop_inc};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_pop && r_tx_count != 16'hFFFF)
        r_tx_count <= r_tx_count + 16'd1;
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign tx_count   = r_tx_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_uart_fifo_rd_ctrl.sv
// tb_uart_fifo_rd_ctrl: directed bench with a latency-accurate FIFO model
// (RAM stage plus output register) feeding uart_fifo_rd_ctrl.

module tb_uart_fifo_rd_ctrl;

  localparam int RD_LAT     = 2;
  localparam int SKID_DEPTH = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       tx_ready = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_do = 8'h00;
  logic       fifo_rdb;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       flush_done;
`ifdef UART_FIFO_RD_CTRL_STATS_EN
  logic [15:0] tx_count;
  logic [15:0] drop_count;
`endif

  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] q[$];
  logic [7:0] d1 = 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc_n, rd_cnt, b2b, first_rd, first_vld;
  int vld_cnt, fd_cnt;
  int hold_err = 0;
  int rx_n = 0;
  int base;
  logic [7:0] rx_buf [64];
  logic       last_rd = 1'b0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  uart_fifo_rd_ctrl #(
    .RD_LAT(RD_LAT),
    .SKID_DEPTH(SKID_DEPTH)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .enable(enable),
    .flush(flush),
    .fifo_empty(fifo_empty),
    .fifo_do(fifo_do),
    .fifo_rdb(fifo_rdb),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .flush_done(flush_done)
`ifdef UART_FIFO_RD_CTRL_STATS_EN
    ,
    .tx_count(tx_count),
    .drop_count(drop_count)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (wr_en) q.push_back(wr_data);
    if (!fifo_rdb && q.size() != 0) d1 <= q.pop_front();
    fifo_do    <= d1;
    fifo_empty <= (q.size() == 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc_n = 0; rd_cnt = 0; b2b = 0;
    first_rd = -1; first_vld = -1;
    vld_cnt = 0; fd_cnt = 0;
  endtask

  task automatic cyc();
    #1;
    cyc_n++;
    if (!fifo_rdb) begin
      rd_cnt++;
      if (last_rd) b2b++;
      if (first_rd < 0) first_rd = cyc_n;
    end
    last_rd = !fifo_rdb;
    if (tx_valid) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc_n;
    end
    if (prev_hold && tx_valid && tx_data !== prev_data) hold_err++;
    prev_hold = tx_valid && !tx_ready;
    prev_data = tx_data;
    if (tx_valid && tx_ready && rx_n < 64) begin
      rx_buf[rx_n] = tx_data;
      rx_n++;
    end
    if (flush_done) fd_cnt++;
    @(negedge CLK);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic wait_rd(input int n, input int lim);
    int k = 0;
    while (rd_cnt < n && k < lim) begin
      cyc();
      k++;
    end
    chk("wait_rd", 32'(rd_cnt >= n), 32'd1);
  endtask

  initial begin
    clr();
    @(negedge CLK);
    #1;
    chk("rst_rdb", fifo_rdb, 1);
    chk("rst_vld", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", flush_done, 0);
    @(negedge CLK);
    RESET = 1'b0;
    run(2);

    // three bytes streamed with the consumer always ready
    wr(8'h11); wr(8'h22); wr(8'h33);
    clr();
    base = rx_n;
    enable = 1'b1;
    tx_ready = 1'b1;
    run(20);
    chk("t1_reads", rd_cnt, 3);
    chk("t1_b2b", b2b, 0);
    chk("t1_lat", first_vld - first_rd, RD_LAT + 1);
    chk("t1_nrx", rx_n - base, 3);
    chk("t1_b0", rx_buf[base], 8'h11);
    chk("t1_b1", rx_buf[base+1], 8'h22);
    chk("t1_b2", rx_buf[base+2], 8'h33);
    enable = 1'b0;
    run(2);
    chk("t1_busy", busy, 0);

    // consumer stalled: credit limits reads to the skid depth
    tx_ready = 1'b0;
    wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
    clr();
    base = rx_n;
    enable = 1'b1;
    run(15);
    chk("t2_reads", rd_cnt, SKID_DEPTH);
    chk("t2_vld", tx_valid, 1);
    chk("t2_head", tx_data, 8'hA1);
    chk("t2_rdb", fifo_rdb, 1);
    tx_ready = 1'b1;
    run(20);
    chk("t2_nrx", rx_n - base, 4);
    chk("t2_b0", rx_buf[base], 8'hA1);
    chk("t2_b1", rx_buf[base+1], 8'hA2);
    chk("t2_b2", rx_buf[base+2], 8'hA3);
    chk("t2_b3", rx_buf[base+3], 8'hA4);
    enable = 1'b0;
    run(2);
    chk("t2_busy", busy, 0);

    // enable dropped right after one read
    wr(8'hB1); wr(8'hB2); wr(8'hB3);
    clr();
    base = rx_n;
    enable = 1'b1;
    wait_rd(1, 10);
    enable = 1'b0;
    run(12);
    chk("t3_reads", rd_cnt, 1);
    chk("t3_nrx", rx_n - base, 1);
    chk("t3_b0", rx_buf[base], 8'hB1);
    chk("t3_busy", busy, 0);

    // FIFO now holds B2,B3 plus eight more: ten bytes, skid fills
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'hC1 + 8'(i));
    clr();
    enable = 1'b1;
    run(12);
    chk("t4_full", tx_valid, 1);
    chk("t4_pre_rd", rd_cnt, 2);
    base = rx_n;
    clr();
    flush = 1'b1;
    enable = 1'b0;
    cyc();
    flush = 1'b0;
    chk("t4_vld0", tx_valid, 0);
    run(40);
    chk("t4_reads", rd_cnt, 8);
    chk("t4_fdone", fd_cnt, 1);
    chk("t4_nrx", rx_n - base, 0);
    chk("t4_busy", busy, 0);
    chk("t4_empty", fifo_empty, 1);
`ifdef UART_FIFO_RD_CTRL_STATS_EN
    chk("t4_drop", drop_count, 10);
    chk("t4_txcnt", tx_count, 8);
`endif

    // empty FIFO: nothing happens until a byte is written
    clr();
    enable = 1'b1;
    tx_ready = 1'b1;
    run(8);
    chk("t5_reads0", rd_cnt, 0);
    chk("t5_vld0", vld_cnt, 0);
    chk("t5_rdb", fifo_rdb, 1);
    base = rx_n;
    wr(8'hD5);
    run(12);
    chk("t5_reads1", rd_cnt, 1);
    chk("t5_nrx", rx_n - base, 1);
    chk("t5_b0", rx_buf[base], 8'hD5);

    // reset in the middle of a stalled stream
    enable = 1'b0;
    run(2);
    tx_ready = 1'b0;
    wr(8'hE1); wr(8'hE2); wr(8'hE3); wr(8'hE4);
    clr();
    enable = 1'b1;
    wait_rd(2, 12);
    RESET = 1'b1;
    #1;
    chk("t6_rdb", fifo_rdb, 1);
    chk("t6_vld", tx_valid, 0);
    chk("t6_data", tx_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_fdone", flush_done, 0);
`ifdef UART_FIFO_RD_CTRL_STATS_EN
    chk("t6_txcnt", tx_count, 0);
    chk("t6_drop", drop_count, 0);
`endif
    enable = 1'b0;
    @(negedge CLK);
    run(2);
    RESET = 1'b0;
    clr();
    base = rx_n;
    tx_ready = 1'b1;
    run(8);
    chk("t6_stale", vld_cnt, 0);
    chk("t6_nrx", rx_n - base, 0);
    chk("t6_busy2", busy, 0);

    chk("hold", hold_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
